clk_div_gen: RTL and testbench
==============================

CLK_DIV_GEN -- requirements
Module: clk_div_gen

Interface
- REQ-001: Parameter WIDTH, default 8; width of the divisor and of the phase counter.
- REQ-002: Parameter DEFAULT_DIV, default 2; divisor after reset; legal range 1..2^WIDTH-1.
- REQ-003: clk  input  1  single clock; all state SHALL update on its rising edge only.
- REQ-004: rst  input  1  reset, synchronous and active-high.
- REQ-005: en  input  1  count enable; phase advances only when high.
- REQ-006: mode  input  1  0 = square output (near-50% duty), 1 = pulse output (one cycle high per period).
- REQ-007: div_in  input  WIDTH  new divisor value D.
- REQ-008: div_load  input  1  one-cycle request to load div_in.
- REQ-009: clk_out  output  1  registered divided clock.
- REQ-010: tick  output  1  registered one-cycle strobe marking the first cycle of each output period.
- REQ-011: fall  output  1  registered one-cycle strobe marking the first low cycle of clk_out in square mode.
- REQ-012: div_cur  output  WIDTH  divisor currently in effect.
- REQ-013: busy  output  1  high while a loaded divisor is pending.

Function
- REQ-014: Internal phase counter p SHALL count 0..D-1 and wrap to 0, advancing by one on each edge with en=1.
- REQ-015: With en=0, p, clk_out and div_cur SHALL hold; tick and fall SHALL be 0 on the next cycle.
- REQ-016: On each edge with en=1, outputs SHALL register the decode of the current p, visible the following cycle (latency 1 from phase to output).
- REQ-017: Decode: tick = (p==0); H = ceil(D/2).
- REQ-018: Square mode: clk_out = (p < H); fall = (p == H) and D >= 2.
- REQ-019: Pulse mode: clk_out = (p == 0); fall = 0.
- REQ-020: D=1: tick SHALL be 1 on every enabled cycle; clk_out SHALL be held 1 in both modes; fall SHALL be 0.
- REQ-021: A div_load with div_in != 0 SHALL be captured into a pending register and set busy=1 on the next cycle.
- REQ-022: A div_load with div_in == 0 SHALL be ignored: no pending, busy unchanged, div_cur unchanged.
- REQ-023: A new div_load while busy=1 SHALL overwrite the pending value; only the last value is applied.
- REQ-024: With en=1, the pending divisor SHALL take effect at the wrap edge (p == D-1), so the next period starts at p=0 with the new D; busy clears on that same edge.
- REQ-025: With en=0, a pending divisor SHALL take effect on the next edge, force p=0, and clear busy; clk_out holds until en rises.
- REQ-026: div_load coinciding with the wrap edge SHALL NOT apply in that wrap; it becomes pending and applies at the following wrap.
- REQ-027: A mode change SHALL take effect on the next edge without resetting p.
- REQ-028: No output SHALL glitch or shorten a period; every period on clk_out is exactly D enabled cycles long.

Reset
- REQ-029: While rst=1, on each edge: p=0, div_cur=DEFAULT_DIV, pending cleared, busy=0, clk_out=0, tick=0, fall=0.
- REQ-030: rst SHALL take priority over en and div_load on the same edge; a load presented with rst is discarded.
- REQ-031: Reset asserted mid-period SHALL abort the period; the first tick after release SHALL occur one cycle after the first enabled edge.

Verification
- REQ-032: Reset, en=1, mode=0, DEFAULT_DIV=4 -> from the cycle after the first enabled edge, clk_out = 1,1,0,0 repeating; tick on each first 1; fall on each first 0.
- REQ-033: mode=0, D=5 loaded while en=0 -> busy=1 for one cycle; after en=1, clk_out = 1,1,1,0,0 repeating; div_cur=5.
- REQ-034: mode=1, D=3, en=1, then load D=6 at p=1 -> the current 3-cycle period completes, then tick every 6 cycles; busy clears at the wrap edge.
- REQ-035: Back-to-back loads 7 then 9 within one period, then load 0 -> the period after the wrap uses D=9; div_cur=9; the 0 is ignored.
- REQ-036: D=1 in both modes -> clk_out constant 1, tick=1 every enabled cycle, fall never asserted; toggling en=0 for 3 cycles -> tick=0 for those cycles, with no phase change.
- REQ-037: rst pulsed for 1 cycle mid-period with D=4 -> all outputs 0 the next cycle, div_cur=4, and the pattern restarts from p=0.

Source files
------------

// File: rtl/clk_div_gen.sv
// Programmable clock divider: square or single-pulse output with a glitch-free
// divisor reload that waits for the end of the current period.
module clk_div_gen #(
   parameter int WIDTH       = 8,
   parameter int DEFAULT_DIV = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             mode,
   input  logic [WIDTH-1:0] div_in,
   input  logic             div_load,
   output logic             clk_out,
   output logic             tick,
   output logic             fall,
   output logic [WIDTH-1:0] div_cur,
   output logic             busy
);

   localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);

   logic [WIDTH-1:0] p;
   logic [WIDTH-1:0] pend;
   logic [WIDTH:0]   half;
   logic             at_wrap;
   logic             load_ok;
   logic             dec_clk;
   logic             dec_tick;
   logic             dec_fall;

   // Load handshake: div_load is a one-cycle request with no back-pressure.
   // A nonzero div_in is latched into pend and busy stays high until the
   // value is applied; a later request simply replaces the pending value.
   assign load_ok = div_load && (div_in != '0);
   assign at_wrap = (p == div_cur - WIDTH'(1));

   always_comb begin
      half     = ({1'b0, div_cur} + (WIDTH+1)'(1)) >> 1;
      dec_tick = (p == '0);
      dec_clk  = 1'b0;
      dec_fall = 1'b0;
      if (mode) begin
         dec_clk = (p == '0);
      end else begin
         dec_clk  = ({1'b0, p} < half);
         dec_fall = ({1'b0, p} == half) && (div_cur >= WIDTH'(2));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         p       <= '0;
         pend    <= '0;
         div_cur <= DEF_DIV;
         busy    <= 1'b0;
         clk_out <= 1'b0;
         tick    <= 1'b0;
         fall    <= 1'b0;
      end else begin
         if (en) begin
            clk_out <= dec_clk;
            tick    <= dec_tick;
            fall    <= dec_fall;
            if (at_wrap) begin
               p <= '0;
               // The new divisor only ever starts a fresh period.
               if (busy) begin
                  div_cur <= pend;
                  busy    <= 1'b0;
               end
            end else begin
               p <= p + WIDTH'(1);
            end
         end else begin
            tick <= 1'b0;
            fall <= 1'b0;
            // No period is running while stalled, so apply at once and rephase.
            if (busy) begin
               div_cur <= pend;
               p       <= '0;
               busy    <= 1'b0;
            end
         end
         // A request on the apply edge stays pending for the following wrap.
         if (load_ok) begin
            pend <= div_in;
            busy <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_clk_div_gen.sv
// Bench for clk_div_gen: directed scenarios plus random traffic, all cycles
// scored against an arithmetic reference model through an expected queue.
module tb_clk_div_gen;

   localparam int WIDTH = 8;
   localparam int DEF   = 4;
   localparam int OW    = WIDTH + 4;

   logic             clk;
   logic             rst;
   logic             en;
   logic             mode;
   logic [WIDTH-1:0] div_in;
   logic             div_load;
   logic             clk_out;
   logic             tick;
   logic             fall;
   logic [WIDTH-1:0] div_cur;
   logic             busy;

   clk_div_gen #(.WIDTH(WIDTH), .DEFAULT_DIV(DEF)) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .mode     (mode),
      .div_in   (div_in),
      .div_load (div_load),
      .clk_out  (clk_out),
      .tick     (tick),
      .fall     (fall),
      .div_cur  (div_cur),
      .busy     (busy)
   );

   // clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      rst      = 1'b1;
      en       = 1'b0;
      mode     = 1'b0;
      div_in   = '0;
      div_load = 1'b0;
   end

   int checks = 0;
   int errors = 0;
   int cycle  = 0;
   logic [OW-1:0] exp_q[$];

   // reference model state
   int m_p = 0, m_d = DEF, m_pend = 0, m_busy = 0;
   int m_clk = 0, m_tick = 0, m_fall = 0;

   function automatic void model_step(input bit r, e, m, input int d, input bit ld);
      if (r) begin
         m_p = 0; m_d = DEF; m_pend = 0; m_busy = 0;
         m_clk = 0; m_tick = 0; m_fall = 0;
      end else begin
         if (e) begin
            m_tick = (m_p == 0);
            if (m) begin
               m_clk  = (m_p == 0);
               m_fall = 0;
            end else begin
               m_clk  = (2 * m_p < m_d);
               m_fall = (m_d >= 2) && (m_p == (m_d + 1) / 2);
            end
            m_p = (m_p + 1) % m_d;
            if (m_p == 0 && m_busy != 0) begin
               m_d = m_pend;
               m_busy = 0;
            end
         end else begin
            m_tick = 0;
            m_fall = 0;
            if (m_busy != 0) begin
               m_d = m_pend; m_p = 0; m_busy = 0;
            end
         end
         if (ld && d != 0) begin
            m_pend = d;
            m_busy = 1;
         end
      end
   endfunction

   // driver: inputs change on the falling edge, expectation for the next rising edge
   task automatic drive(input bit r, e, m, input int d, input bit ld);
      logic [OW-1:0] x;
      @(negedge clk);
      rst = r; en = e; mode = m; div_in = d[WIDTH-1:0]; div_load = ld;
      model_step(r, e, m, d, ld);
      x = {m_clk[0], m_tick[0], m_fall[0], m_busy[0], m_d[WIDTH-1:0]};
      exp_q.push_back(x);
   endtask

   task automatic sample();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic run_seq(input int n, input bit e, m, input int ld_at, ld_val,
                          output logic [31:0] co, tk, fl, bz);
      co = '0; tk = '0; fl = '0; bz = '0;
      for (int i = 0; i < n; i++) begin
         drive(1'b0, e, m, ld_val, (i == ld_at));
         sample();
         co = {co[30:0], clk_out};
         tk = {tk[30:0], tick};
         fl = {fl[30:0], fall};
         bz = {bz[30:0], busy};
      end
   endtask

   // scoreboard monitor
   initial begin
      logic [OW-1:0] e;
      logic [OW-1:0] a;
      forever begin
         @(posedge clk);
         #1;
         cycle++;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {clk_out, tick, fall, busy, div_cur};
            checks++;
            if (a !== e) begin
               errors++;
               $display("FAIL scoreboard cycle %0d: got {clk,tick,fall,busy,div}=%h expected %h",
                        cycle, a, e);
            end
         end
      end
   end

   initial begin
      logic [31:0] co, tk, fl, bz;
      bit r, e, m, ld;
      int d;

      // reset state and default divide-by-4 square pattern
      drive(1, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0);
      sample();
      chk("reset_flags", {28'd0, clk_out, tick, fall, busy}, 32'd0);
      chk("reset_div", 32'(div_cur), 32'd4);
      run_seq(8, 1, 0, -1, 0, co, tk, fl, bz);
      chk("d4_clk", co, 32'b11001100);
      chk("d4_tick", tk, 32'b10001000);
      chk("d4_fall", fl, 32'b00100010);

      // load 5 while stalled
      drive(1, 0, 0, 0, 0);
      drive(0, 0, 0, 5, 1);
      sample();
      chk("d5_busy_set", 32'(busy), 32'd1);
      drive(0, 0, 0, 0, 0);
      sample();
      chk("d5_busy_clr", 32'(busy), 32'd0);
      chk("d5_div", 32'(div_cur), 32'd5);
      run_seq(10, 1, 0, -1, 0, co, tk, fl, bz);
      chk("d5_clk", co, 32'b1110011100);

      // pulse mode, D=3 then load 6 at p=1
      drive(1, 0, 1, 0, 0);
      drive(0, 0, 1, 3, 1);
      drive(0, 0, 1, 0, 0);
      run_seq(12, 1, 1, 1, 6, co, tk, fl, bz);
      chk("d3to6_tick", tk, 32'b100100000100);
      chk("d3to6_busy", bz, 32'b010000000000);
      chk("d3to6_clk", co, 32'b100100000100);

      // back-to-back loads 7, 9, then 0 inside one D=4 period
      drive(1, 0, 0, 0, 0);
      drive(0, 1, 0, 7, 1);
      drive(0, 1, 0, 9, 1);
      drive(0, 1, 0, 0, 1);
      drive(0, 1, 0, 0, 0);
      sample();
      chk("d9_div", 32'(div_cur), 32'd9);
      chk("d9_busy", 32'(busy), 32'd0);
      run_seq(9, 1, 0, -1, 0, co, tk, fl, bz);
      chk("d9_clk", co, 32'b111110000);
      chk("d9_tick", tk, 32'b100000000);
      chk("d9_fall", fl, 32'b000001000);

      // D=1 in both modes with an en gap
      drive(1, 0, 0, 0, 0);
      drive(0, 0, 0, 1, 1);
      drive(0, 0, 0, 0, 0);
      run_seq(4, 1, 0, -1, 0, co, tk, fl, bz);
      chk("d1_sq", {co[3:0], tk[3:0], fl[3:0]}, 32'b111111110000);
      run_seq(3, 0, 0, -1, 0, co, tk, fl, bz);
      chk("d1_stall", {co[2:0], tk[2:0]}, 32'b111000);
      run_seq(4, 1, 1, -1, 0, co, tk, fl, bz);
      chk("d1_pulse", {co[3:0], tk[3:0], fl[3:0]}, 32'b111111110000);

      // reset pulse mid-period, with a load that must be discarded
      drive(1, 0, 0, 0, 0);
      run_seq(6, 1, 0, -1, 0, co, tk, fl, bz);
      drive(1, 1, 0, 7, 1);
      sample();
      chk("midrst_flags", {28'd0, clk_out, tick, fall, busy}, 32'd0);
      chk("midrst_div", 32'(div_cur), 32'd4);
      run_seq(4, 1, 0, -1, 0, co, tk, fl, bz);
      chk("midrst_clk", co, 32'b1100);
      chk("midrst_tick", tk, 32'b1000);

      // random traffic, scored only through the queue
      m = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         r  = ($urandom_range(0, 99) == 0);
         e  = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 19) == 0) m = ~m;
         ld = ($urandom_range(0, 7) == 0);
         case ($urandom_range(0, 7))
            0:       d = 0;
            1:       d = 1;
            2:       d = $urandom_range(13, 255);
            default: d = $urandom_range(2, 12);
         endcase
         drive(r, e, m, d, ld);
      end
      drive(0, 0, m, 0, 0);
      repeat (3) @(posedge clk);
      #2;
      chk("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
